// File: rtl/dapuf_eval_ctrl.sv
// dapuf_eval_ctrl: evaluation sequencer for a double-arbiter PUF core.
// Takes a challenge over a valid/ready request channel. Runs one LOAD phase,
// then NUM_EVAL FIRE/RELAX evaluations. Majority-votes the sampled response
// bits and returns the voted bit plus an all-samples-agree flag over a
// valid/ready response channel.
//
// Optional feature macro: DAPUF_EVAL_RESP_SYNC_EN
//   defined   : puf_response goes through a 2-flop synchronizer (SYNC_LAT=2).
//   undefined : puf_response is sampled directly (SYNC_LAT=0). Use this only
//               in simulation, or when the PUF output is already in the clk domain.
module dapuf_eval_ctrl #(
    parameter int CHAL_W     = 16,
    parameter int SETTLE_CYC = 8,
    parameter int NUM_EVAL   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAL_W-1:0] req_challenge,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_exciteL,
    output logic              puf_exciteR,
    input  logic              puf_response,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_bit,
    output logic              rsp_stable
);

`ifdef DAPUF_EVAL_RESP_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    // FIRE is stretched by the synchronizer depth. The sampled bit then
    // reflects the response of this firing, not a stale value.
    localparam int FIRE_CYC = SETTLE_CYC + SYNC_LAT;
    localparam int PH_W     = $clog2(FIRE_CYC + 1);
    localparam int ONES_W   = $clog2(NUM_EVAL + 1);

    localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]   FIRE_LAST   = PH_W'(FIRE_CYC - 1);
    localparam logic [ONES_W-1:0] EVAL_MAX    = ONES_W'(NUM_EVAL);
    localparam logic [ONES_W-1:0] VOTE_HALF   = ONES_W'(NUM_EVAL / 2);

    // Reject parameter values that make the vote ambiguous or a phase empty.
    if (NUM_EVAL < 1 || (NUM_EVAL % 2) == 0) begin : g_bad_num_eval
        $error("dapuf_eval_ctrl: NUM_EVAL must be odd and >= 1");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("dapuf_eval_ctrl: SETTLE_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FIRE  = 3'd2,
        RELAX = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [ONES_W-1:0]   eval_q, eval_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic                excite_q, excite_d;
    logic                sample;

`ifdef DAPUF_EVAL_RESP_SYNC_EN
    logic [1:0] sync_q, sync_d;

    // Shift the asynchronous response into the clk domain.
    always_comb begin
        sync_d = {sync_q[0], puf_response};
    end

    // Synchronizer flops. They reset to 0 so a reset leaves no stale sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = puf_response;
`endif

    // Next-state logic: phase sequencing, vote accumulation and challenge capture.
    always_comb begin
        // NOTE: every variable gets a default before the case. Paths that do not
        // assign a variable then hold its value instead of inferring a latch.
        state_d = state_q;
        phase_d = phase_q;
        ones_d  = ones_q;
        eval_d  = eval_q;
        chal_d  = chal_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    chal_d  = req_challenge;
                    ones_d  = '0;
                    eval_d  = '0;
                    phase_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (phase_q == SETTLE_LAST) begin
                    phase_d = '0;
                    state_d = FIRE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            FIRE: begin
                if (phase_q == FIRE_LAST) begin
                    phase_d = '0;
                    ones_d  = ones_q + ONES_W'(sample);
                    eval_d  = eval_q + 1'b1;
                    state_d = RELAX;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RELAX: begin
                if (phase_q == SETTLE_LAST) begin
                    phase_d = '0;
                    state_d = (eval_q == EVAL_MAX) ? DONE : FIRE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // One flop drives both excitation lines. Both edges therefore leave on
        // the same clock edge.
        excite_d = (state_d == FIRE);
    end

    // State and datapath registers. Async reset drops the excites immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments here let every flop sample the
        // pre-edge values, with no dependence on statement order.
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            ones_q   <= '0;
            eval_q   <= '0;
            chal_q   <= '0;
            excite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ones_q   <= ones_d;
            eval_q   <= eval_d;
            chal_q   <= chal_d;
            excite_q <= excite_d;
        end
    end

    // Handshake and result outputs are decoded from registered state only.
    always_comb begin
        req_ready  = (state_q == IDLE);
        rsp_valid  = (state_q == DONE);
        rsp_bit    = (state_q == DONE) && (ones_q > VOTE_HALF);
        rsp_stable = (state_q == DONE) && ((ones_q == '0) || (ones_q == EVAL_MAX));
    end

    assign puf_challenge = chal_q;
    assign puf_exciteL   = excite_q;
    assign puf_exciteR   = excite_q;

endmodule

// File: tb/tb_dapuf_eval_ctrl.sv
// Self-checking bench for dapuf_eval_ctrl (CHAL_W=16, SETTLE_CYC=4, NUM_EVAL=3).
// A timeline model derives every expected output from the number of edges
// since acceptance. The directed table pins the voted results and latency.
// Cycle n is the cycle that ends at edge n. The accept edge is edge 0.
module tb_dapuf_eval_ctrl;

    localparam int CHAL_W = 16;
    localparam int S      = 4;
    localparam int N      = 3;
`ifdef DAPUF_EVAL_RESP_SYNC_EN
    localparam int L       = 2;
    localparam int EXP_LAT = 35;
`else
    localparam int L       = 0;
    localparam int EXP_LAT = 29;
`endif
    localparam int P      = 2 * S + L;   // one FIRE + RELAX evaluation
    localparam int T_DONE = S + N * P;   // edges after accept until DONE

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [CHAL_W-1:0] req_challenge = '0;
    logic [CHAL_W-1:0] puf_challenge;
    logic              puf_exciteL, puf_exciteR;
    logic              puf_response = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_bit, rsp_stable;

    int checks = 0;
    int errors = 0;

    // Model state.
    bit                busy = 1'b0;
    int                k = 0;
    logic [CHAL_W-1:0] exp_chal = '0;
    logic [2:0]        pat = '0;
    logic [2:0]        cur_pat = '0;

    dapuf_eval_ctrl #(.CHAL_W(CHAL_W), .SETTLE_CYC(S), .NUM_EVAL(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
        .puf_challenge(puf_challenge), .puf_exciteL(puf_exciteL), .puf_exciteR(puf_exciteR),
        .puf_response(puf_response),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit), .rsp_stable(rsp_stable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_done();
        return busy && (k >= T_DONE);
    endfunction

    function automatic bit m_excite();
        if (!busy || k < S || k >= T_DONE) return 1'b0;
        return ((k - S) % P) < (S + L);
    endfunction

    function automatic logic m_bit();
        return $countones(pat) > (N / 2);
    endfunction

    function automatic logic m_stable();
        return ($countones(pat) == 0) || ($countones(pat) == N);
    endfunction

    // Model timeline: acceptance, edge counting and response consumption.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            if (k >= T_DONE && rsp_ready) busy = 1'b0;
            else k = k + 1;
        end else if (req_valid) begin
            busy     = 1'b1;
            k        = 0;
            exp_chal = req_challenge;
            pat      = cur_pat;
        end
    end

    // PUF stand-in. It shows pat[e] during evaluation e's FIRE phase. Outside
    // FIRE it shows the opposite value, so a sample taken at the wrong time is wrong.
    always @(negedge clk) begin
        int e;
        e = (k < S) ? 0 : (k - S) / P;
        if (!busy) puf_response = 1'b0;
        else if (m_excite()) puf_response = pat[e];
        else if (k < S) puf_response = ~pat[0];
        else if (e + 1 < N) puf_response = ~pat[e+1];
        else puf_response = 1'b0;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("excite_lr_equal", puf_exciteL, puf_exciteR);
        check("req_ready", req_ready, !busy);
        check("excite", puf_exciteL, m_excite());
        check("rsp_valid", rsp_valid, m_done());
        if (busy) check("puf_challenge", puf_challenge, exp_chal);
        if (m_done()) begin
            check("rsp_bit", rsp_bit, m_bit());
            check("rsp_stable", rsp_stable, m_stable());
        end
    end

    task automatic run_req(input logic [15:0] chal, input logic [2:0] p, input logic exp_bit,
                           input logic exp_st, input int hold, input bit keep_valid,
                           input bit scramble);
        bit got;
        @(negedge clk);
        cur_pat = p;
        req_challenge = chal;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin got = 1'b1; break; end
        end
        check("accept_timeout", got, 1'b1);
        if (!keep_valid) req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
            if (scramble) req_challenge = 16'($urandom);
        end
        check("latency", got ? 32'(k + 1) : 32'hFFFF_FFFF, 32'(EXP_LAT));
        check("lit_rsp_bit", rsp_bit, exp_bit);
        check("lit_rsp_stable", rsp_stable, exp_st);
        check("lit_challenge", puf_challenge, chal);
        repeat (hold) @(negedge clk);
        check("held_valid", rsp_valid, 1'b1);
        check("held_bit", rsp_bit, exp_bit);
        check("held_stable", rsp_stable, exp_st);
        check("held_req_ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_consume", req_ready, 1'b1);
        check("valid_dropped", rsp_valid, 1'b0);
    endtask

    initial begin
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_excite", {puf_exciteL, puf_exciteR}, 2'b00);
        check("rst_challenge", puf_challenge, 16'h0000);
        check("rst_bit_stable", {rsp_bit, rsp_stable}, 2'b00);
        @(negedge clk);
        #2 rst = 1'b0;

        run_req(16'hA5A5, 3'b111, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        run_req(16'h3C3C, 3'b000, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_req(16'h1234, 3'b101, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        run_req(16'h4321, 3'b010, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_req(16'hBEEF, 3'b011, 1'b1, 1'b0, 2, 1'b0, 1'b1);

        // Hold the response 10 cycles with req_valid held high throughout.
        run_req(16'hCAFE, 3'b100, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        @(negedge clk);
        check("held_req_accepted", req_ready, 1'b0);
        run_req(16'hCAFE, 3'b100, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Assert reset asynchronously during the second FIRE phase.
        begin
            bit got;
            @(negedge clk);
            cur_pat = 3'b111;
            req_challenge = 16'h7777;
            req_valid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (busy) req_valid = 1'b0;
                if (busy && k == S + P + 1) begin got = 1'b1; break; end
            end
            check("reach_fire2", got, 1'b1);
            check("pre_reset_excite", puf_exciteL, 1'b1);
            #2 rst = 1'b1;
            #1;
            check("async_excite_drop", {puf_exciteL, puf_exciteR}, 2'b00);
            check("async_valid_low", rsp_valid, 1'b0);
            repeat (3) @(negedge clk);
            #2 rst = 1'b0;
            repeat (40) @(negedge clk);
            check("no_rsp_after_reset", rsp_valid, 1'b0);
        end
        run_req(16'h5A5A, 3'b110, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
